// File: rtl/rc4_xor_stream_pkg.sv
// Shared types and constants for the RC4 keystream XOR stage.
package rc4_xor_stream_pkg;

   typedef enum logic [1:0] {
      ST_PRIME = 2'd0,
      ST_RUN   = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   localparam int KS_MSB       = 9;
   localparam int KS_LSB       = 2;
   localparam int KS_W         = KS_MSB - KS_LSB + 1;
   localparam int BYTE_COUNT_W = 32;

endpackage

// File: rtl/rc4_ks_fifo.sv
// Keystream byte FIFO; push accepted when not full or when a pop shares the cycle.
// Latency: head valid the cycle after the first push; level updates every edge.
// Backpressure: none upstream; the caller detects a refused push via full.
module rc4_ks_fifo
   import rc4_xor_stream_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [KS_W-1:0]          push_data,
   input  logic                     pop,
   output logic [KS_W-1:0]          head_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [KS_W-1:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            push_ok;
   logic            pop_ok;

   assign full      = (level == LW'(DEPTH));
   assign empty     = (level == '0);
   assign pop_ok    = pop && !empty;
   assign push_ok   = push && (!full || pop_ok);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers are exactly AW bits so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/rc4_xor_stream.sv
// Buffers RC4 keystream bytes and XORs them with plaintext into ciphertext.
// Latency: one cycle from plaintext acceptance to ct_valid.
// Backpressure: ct_ready stalls pt_ready; keystream overflow halts until reset.
module rc4_xor_stream
   import rc4_xor_stream_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int START_LEVEL = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ks_valid,
   input  logic [9:0]                ks_data,
   input  logic                      pt_valid,
   output logic                      pt_ready,
   input  logic [7:0]                pt_data,
   output logic                      ct_valid,
   input  logic                      ct_ready,
   output logic [7:0]                ct_data,
   output logic [$clog2(DEPTH):0]    ks_level,
   output logic                      ks_overflow,
   output logic [BYTE_COUNT_W-1:0]   byte_count
);

   localparam int             LW       = $clog2(DEPTH) + 1;
   localparam logic [LW-1:0]  START_LV = LW'(START_LEVEL);

   state_t          state;
   state_t          state_nxt;
   logic            push_req;
   logic            fire;
   logic            overflow_evt;
   logic            ks_full;
   logic            ks_empty;
   logic [KS_W-1:0] ks_head;
   logic            unused_ks_bits;

   assign unused_ks_bits = ^ks_data[KS_LSB-1:0];

   // Once halted, cipher sync is lost; further keystream words are meaningless.
   assign push_req     = ks_valid && (state != ST_HALT);
   assign pt_ready     = (state == ST_RUN) && !ks_empty && (!ct_valid || ct_ready);
   assign fire         = pt_valid && pt_ready;
   assign overflow_evt = push_req && ks_full && !fire;

   rc4_ks_fifo #(
      .DEPTH (DEPTH)
   ) u_ks_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_req),
      .push_data (ks_data[KS_MSB:KS_LSB]),
      .pop       (fire),
      .head_data (ks_head),
      .level     (ks_level),
      .full      (ks_full),
      .empty     (ks_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_PRIME;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_PRIME: begin
            if (overflow_evt) begin
               state_nxt = ST_HALT;
            end else if (ks_level >= START_LV) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (overflow_evt) begin
               state_nxt = ST_HALT;
            end
         end
         ST_HALT: begin
            state_nxt = ST_HALT;
         end
         default: begin
            state_nxt = ST_PRIME;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ct_valid   <= 1'b0;
         ct_data    <= '0;
         byte_count <= '0;
      end else if (fire) begin
         ct_valid   <= 1'b1;
         ct_data    <= pt_data ^ ks_head;
         byte_count <= byte_count + BYTE_COUNT_W'(1);
      end else if (ct_valid && ct_ready) begin
         ct_valid   <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ks_overflow <= 1'b0;
      end else if (overflow_evt) begin
         ks_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rc4_xor_stream.sv
// Directed plus randomized bench for rc4_xor_stream against a queue-based model.
module tb_rc4_xor_stream;

   localparam int DEPTH = 16;
   localparam int START = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        ks_valid;
   logic [9:0]  ks_data;
   logic        pt_valid;
   logic        pt_ready;
   logic [7:0]  pt_data;
   logic        ct_valid;
   logic        ct_ready;
   logic [7:0]  ct_data;
   logic [4:0]  ks_level;
   logic        ks_overflow;
   logic [31:0] byte_count;

   int checks = 0;
   int errors = 0;

   // Reference model: keystream bytes in arrival order plus output register image.
   logic [7:0]  ks_q[$];
   bit          m_run;
   bit          m_halt;
   bit          m_ovf;
   bit          m_ctv;
   logic [7:0]  m_ctd;
   logic [31:0] m_cnt;

   always #5 clk = ~clk;

   rc4_xor_stream #(
      .DEPTH       (DEPTH),
      .START_LEVEL (START)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ks_valid    (ks_valid),
      .ks_data     (ks_data),
      .pt_valid    (pt_valid),
      .pt_ready    (pt_ready),
      .pt_data     (pt_data),
      .ct_valid    (ct_valid),
      .ct_ready    (ct_ready),
      .ct_data     (ct_data),
      .ks_level    (ks_level),
      .ks_overflow (ks_overflow),
      .byte_count  (byte_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: check pt_ready before the edge, advance the model, check outputs after.
   task automatic tick();
      bit         exp_rdy;
      bit         fire;
      int         lvl_before;
      logic [7:0] head;
      #1;
      exp_rdy = m_run && !m_halt && (ks_q.size() != 0) && (!m_ctv || ct_ready);
      chk("pt_ready", 32'(pt_ready), 32'(exp_rdy));
      fire       = pt_valid && exp_rdy;
      lvl_before = ks_q.size();
      if (rst) begin
         ks_q.delete();
         m_run  = 0;
         m_halt = 0;
         m_ovf  = 0;
         m_ctv  = 0;
         m_ctd  = 8'h00;
         m_cnt  = 0;
      end else begin
         if (fire) begin
            head  = ks_q.pop_front();
            m_ctd = pt_data ^ head;
            m_ctv = 1;
            m_cnt = m_cnt + 1;
         end else if (m_ctv && ct_ready) begin
            m_ctv = 0;
         end
         if (ks_valid && !m_halt) begin
            if (ks_q.size() < DEPTH) begin
               ks_q.push_back(ks_data[9:2]);
            end else begin
               m_ovf  = 1;
               m_halt = 1;
            end
         end
         if (lvl_before >= START) m_run = 1;
      end
      @(posedge clk);
      #1;
      chk("ks_level",    32'(ks_level),    32'(ks_q.size()));
      chk("ct_valid",    32'(ct_valid),    32'(m_ctv));
      chk("ct_data",     32'(ct_data),     32'(m_ctd));
      chk("ks_overflow", 32'(ks_overflow), 32'(m_ovf));
      chk("byte_count",  byte_count,       m_cnt);
   endtask

   initial begin
      rst      = 1'b1;
      ks_valid = 1'b0;
      ks_data  = '0;
      pt_valid = 1'b0;
      pt_data  = '0;
      ct_ready = 1'b0;
      m_run = 0; m_halt = 0; m_ovf = 0; m_ctv = 0; m_ctd = 8'h00; m_cnt = 0;
      tick();
      tick();
      chk("reset_level", 32'(ks_level), 32'd0);
      chk("reset_ct_data", 32'(ct_data), 32'h0);
      rst = 1'b0;

      // Priming: plaintext offered early must wait for START_LEVEL words.
      pt_valid = 1'b1;
      pt_data  = 8'hA5;
      ct_ready = 1'b1;
      ks_data  = 10'h3FC;
      repeat (3) begin
         ks_valid = 1'b1;
         tick();
      end
      ks_valid = 1'b0;
      tick();
      tick();
      chk("prime_ready_low", 32'(pt_ready), 32'd0);
      ks_valid = 1'b1;
      tick();
      ks_valid = 1'b0;
      tick();
      chk("prime_ready_high", 32'(pt_ready), 32'd1);
      tick();
      chk("basic_ct_data", 32'(ct_data), 32'h5A);
      chk("basic_count", byte_count, 32'd1);
      chk("basic_level", 32'(ks_level), 32'd3);

      // Backpressure: held output, then back-to-back handoff with no bubble.
      ct_ready = 1'b0;
      pt_data  = 8'h3C;
      tick();
      tick();
      chk("bp_hold_data", 32'(ct_data), 32'h5A);
      chk("bp_ready_low", 32'(pt_ready), 32'd0);
      ct_ready = 1'b1;
      tick();
      chk("bp_next_data", 32'(ct_data), 32'hC3);
      chk("bp_next_valid", 32'(ct_valid), 32'd1);
      pt_valid = 1'b0;
      tick();

      // Fill to full, then push and pop every cycle across pointer wrap.
      ks_valid = 1'b1;
      for (int i = 0; i < DEPTH && ks_q.size() < DEPTH; i++) begin
         ks_data = 10'($urandom);
         tick();
      end
      chk("full_level", 32'(ks_level), 32'd16);
      pt_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         ks_data = 10'($urandom);
         pt_data = 8'($urandom);
         tick();
      end
      chk("wrap_level", 32'(ks_level), 32'd16);
      chk("wrap_no_ovf", 32'(ks_overflow), 32'd0);
      ks_valid = 1'b0;
      pt_valid = 1'b0;

      // Random traffic kept below overflow.
      for (int i = 0; i < 300; i++) begin
         ks_valid = ($urandom_range(0, 1) == 1) && (ks_q.size() < DEPTH - 1);
         ks_data  = 10'($urandom);
         pt_valid = ($urandom_range(0, 3) != 0);
         pt_data  = 8'($urandom);
         ct_ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      // Reset while a ciphertext byte is pending and seven words are buffered.
      rst = 1'b1;
      ks_valid = 1'b0;
      pt_valid = 1'b0;
      tick();
      rst = 1'b0;
      ct_ready = 1'b0;
      ks_valid = 1'b1;
      repeat (8) begin
         ks_data = 10'($urandom);
         tick();
      end
      ks_valid = 1'b0;
      pt_valid = 1'b1;
      pt_data  = 8'($urandom);
      tick();
      pt_valid = 1'b0;
      tick();
      chk("mid_level7", 32'(ks_level), 32'd7);
      chk("mid_ctv", 32'(ct_valid), 32'd1);
      rst = 1'b1;
      tick();
      chk("rst_ct_valid", 32'(ct_valid), 32'd0);
      chk("rst_level", 32'(ks_level), 32'd0);
      chk("rst_count", byte_count, 32'd0);
      chk("rst_ovf", 32'(ks_overflow), 32'd0);
      rst = 1'b0;
      pt_valid = 1'b1;
      tick();

      // Overflow: seventeen pulses with no consumption.
      pt_valid = 1'b0;
      ct_ready = 1'b1;
      ks_valid = 1'b1;
      repeat (16) begin
         ks_data = 10'($urandom);
         tick();
      end
      chk("pre_ovf", 32'(ks_overflow), 32'd0);
      tick();
      chk("ovf_flag", 32'(ks_overflow), 32'd1);
      chk("ovf_level", 32'(ks_level), 32'd16);
      pt_valid = 1'b1;
      repeat (3) tick();
      chk("halt_ready", 32'(pt_ready), 32'd0);
      chk("halt_level", 32'(ks_level), 32'd16);
      chk("halt_ovf", 32'(ks_overflow), 32'd1);
      ks_valid = 1'b0;
      pt_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rc4_xor_stream.md
Name: rc4_xor_stream

Overview:
Downstream consumer of the RC4 PRGA keystream stage. It captures each keystream word on the generator's single-cycle valid pulse into a small FIFO. It XORs buffered keystream bytes with a plaintext byte stream under valid/ready handshakes and emits ciphertext. The generator has no backpressure, so overflow is detected, flagged, and halts the stream: a lost keystream word means loss of cipher sync.

Parameters:
DEPTH, 16, keystream FIFO entries; power of 2, at least 4.
START_LEVEL, 4, FIFO occupancy required before the first plaintext byte is accepted; 1..DEPTH.

Ports:
clk  in  1  clock; single clock domain.
rst  in  1  reset; synchronous, active-high.
ks_valid  in  1  keystream word valid; single-cycle pulse from the PRGA stage.
ks_data  in  10  keystream word; keystream byte = ks_data[9:2].
pt_valid  in  1  plaintext byte valid.
pt_ready  out  1  plaintext byte accepted this cycle when high together with pt_valid.
pt_data  in  8  plaintext byte.
ct_valid  out  1  ciphertext valid.
ct_ready  in  1  downstream accepts ciphertext.
ct_data  out  8  ciphertext byte.
ks_level  out  log2(DEPTH)+1  current FIFO occupancy.
ks_overflow  out  1  sticky: a keystream word was dropped.
byte_count  out  32  count of ciphertext bytes produced; wraps at 2^32.

Behaviour:
- Reset (synchronous, active-high, clk rising edge): FIFO emptied, ks_level=0, ct_valid=0, ct_data=0, ks_overflow=0, byte_count=0, state=PRIME. pt_ready is combinational and therefore 0 after reset.
- States: PRIME, RUN, HALT.
  - PRIME -> RUN when ks_level >= START_LEVEL (registered compare; RUN is entered the cycle after the level is reached).
  - PRIME or RUN -> HALT on overflow.
  - HALT is left only by rst.
- Push rule: on ks_valid, push ks_data[9:2].
  - Push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the word is dropped, ks_overflow<=1 and the next state is HALT.
  - Back-to-back ks_valid pulses must be supported.
- pt_ready = (state==RUN) && (ks_level!=0) && (!ct_valid || ct_ready).
- Fire = pt_valid && pt_ready. On fire:
  - ct_data <= pt_data ^ FIFO head; ct_valid<=1; FIFO pops; byte_count increments.
  - Latency is 1 cycle from the accepting edge to ct_valid.
- ct_valid clears when ct_ready && ct_valid && !fire. ct_data and ct_valid hold stable while ct_valid && !ct_ready.
- Simultaneous push and pop: ks_level is unchanged and the FIFO order is preserved. When the FIFO is empty, no pop is possible, so only the push occurs.
- Pointer wrap-around: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full is ks_level==DEPTH.
- HALT:
  - pt_ready=0; pushes are ignored and ks_overflow stays 1.
  - Any pending ct_valid is still delivered to the consumer.
  - ks_level is frozen.
- Reset mid-operation: all state returns to reset values on the next edge; any in-flight ct byte is discarded.
- Underflow cannot occur: no pop while empty, guaranteed by pt_ready.

Decomposition:
- Shared package: state encodings (PRIME/RUN/HALT), the keystream byte slice constant (KS_MSB=9, KS_LSB=2), and the byte_count width.
- One sub-module, rc4_ks_fifo: synchronous FIFO with DEPTH, push/pop, head data, level, full/empty, and supporting push while full when a pop occurs in the same cycle.
- The XOR, handshake, FSM and counter logic live in rc4_xor_stream.

Test Plan:
- Priming: 3 ks_valid pulses with ks_data=10'h3FC and pt_valid held high -> pt_ready stays 0. After a 4th pulse, pt_ready=1 the following cycle.
- Basic XOR: FIFO primed with byte 8'hFF (ks_data 10'h3FC); pt_data=8'hA5 accepted -> next cycle ct_valid=1, ct_data=8'h5A, byte_count=1, ks_level decrements by 1.
- Backpressure: ct_ready=0 after the first output -> pt_ready=0, ct_data holds 8'h5A. Raise ct_ready together with pt_valid -> a new byte is issued in the same cycle the old one is accepted, with no bubble.
- Overflow: DEPTH=16, 17 pulses with pt_valid=0 -> on the 17th, ks_overflow=1 and the next cycle state=HALT with pt_ready=0. ks_level=16 and stays frozen across further pulses.
- Push while full with a pop in the same cycle: FIFO full, ks_valid coincides with a fire -> no overflow, ks_level stays 16. The output order matches the push order across pointer wrap (check 40 bytes against a reference XOR model).
- Reset mid-stream: assert rst while ct_valid=1 and ks_level=7 -> after that edge ct_valid=0, ks_level=0, byte_count=0, ks_overflow=0, state=PRIME.
